// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit position index through the set bits of a mask,
// holding each for a programmable dwell. Define SCAN_SEQUENCER_BLANK_EN to insert a blank cycle between positions.
module scan_sequencer #(
  parameter int DWELL_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               STOP,
  input  logic [7:0]         MASK,
  input  logic [DWELL_W-1:0] DWELL,
  output logic [2:0]         SEL,
  output logic               SEL_VALID,
  output logic               SWEEP_DONE,
  output logic               BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef SCAN_SEQUENCER_BLANK_EN
    S_BLANK = 2'd2,
`endif
    S_DWELL = 2'd1
  } state_t;

  // State entered whenever the index moves to a new position.
`ifdef SCAN_SEQUENCER_BLANK_EN
  localparam state_t ADV_STATE = S_BLANK;
`else
  localparam state_t ADV_STATE = S_DWELL;
`endif

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               sel_valid_q, sel_valid_d;
  logic               sweep_done_q, sweep_done_d;
  logic               busy_q, busy_d;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

  function automatic logic has_above(input logic [7:0] m, input logic [2:0] idx);
    has_above = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && i > int'(idx)) has_above = 1'b1;
    end
  endfunction

  function automatic logic [2:0] next_above(input logic [7:0] m, input logic [2:0] idx);
    next_above = idx;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && i > int'(idx)) next_above = 3'(i);
    end
  endfunction

  // The counter runs down to zero, so a dwell of 0 or 1 both give one cycle.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    dwell_load = (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  // NOTE: every signal gets a default at the top of the comb block; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (START && !STOP && MASK != '0) begin
          state_d = S_DWELL;
          mask_d  = MASK;
          dwell_d = DWELL;
          sel_d   = lowest_set(MASK);
          cnt_d   = dwell_load(DWELL);
        end
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (has_above(mask_q, sel_q)) begin
          state_d = ADV_STATE;
          sel_d   = next_above(mask_q, sel_q);
          cnt_d   = dwell_load(dwell_q);
        end else begin
          // Wrap: the next sweep runs on freshly sampled mask and dwell.
          mask_d  = MASK;
          dwell_d = DWELL;
          if (MASK == '0) begin
            state_d = S_IDLE;
            sel_d   = 3'd0;
            cnt_d   = '0;
          end else begin
            state_d = ADV_STATE;
            sel_d   = lowest_set(MASK);
            cnt_d   = dwell_load(DWELL);
          end
        end
      end
`ifdef SCAN_SEQUENCER_BLANK_EN
      S_BLANK: state_d = S_DWELL;
`endif
      default: begin
        state_d = S_IDLE;
        sel_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
    if (STOP) begin
      state_d = S_IDLE;
      sel_d   = 3'd0;
      cnt_d   = '0;
    end
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    sel_valid_d  = (state_d == S_DWELL);
    sweep_done_d = (state_d == S_DWELL) && (cnt_d == '0) && !has_above(mask_d, sel_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, and the
  // captured mask/dwell registers are cleared by reset along with the FSM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      sel_q        <= 3'd0;
      mask_q       <= '0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      sel_valid_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mask_q       <= mask_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      sel_valid_q  <= sel_valid_d;
      sweep_done_q <= sweep_done_d;
      busy_q       <= busy_d;
    end
  end

  assign SEL        = sel_q;
  assign SEL_VALID  = sel_valid_q;
  assign SWEEP_DONE = sweep_done_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer; picks the blank-cycle
// scenarios when SCAN_SEQUENCER_BLANK_EN is defined.
module tb_scan_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        STOP;
  logic [7:0]  MASK;
  logic [15:0] DWELL;
  logic [2:0]  SEL;
  logic        SEL_VALID;
  logic        SWEEP_DONE;
  logic        BUSY;

  int checks   = 0;
  int failures = 0;

  scan_sequencer #(.DWELL_W(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .STOP       (STOP),
    .MASK       (MASK),
    .DWELL      (DWELL),
    .SEL        (SEL),
    .SEL_VALID  (SEL_VALID),
    .SWEEP_DONE (SWEEP_DONE),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed outputs packed as {BUSY, SEL_VALID, SWEEP_DONE, SEL}.
  function automatic logic [5:0] obs();
    return {BUSY, SEL_VALID, SWEEP_DONE, SEL};
  endfunction

  function automatic logic [5:0] ex(input logic busy, input logic valid,
                                    input logic done, input logic [2:0] sel);
    return {busy, valid, done, sel};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got(busy,valid,done,sel)=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_stop();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  logic [2:0] t2_sel [0:2]   = '{3'd0, 3'd2, 3'd7};
  logic [2:0] t3_sel [0:12]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5,
                                 3'd6, 3'd6, 3'd7, 3'd7, 3'd4};
  logic       t3_done [0:12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       tb_valid [0:5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [2:0] tb_sel [0:5]   = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
  logic       tb_done [0:5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
    MASK  = 8'h00;
    DWELL = 16'd0;
    tick();
    tick();
    check("reset_state", obs(), ex(0, 0, 0, 0));
    RST_N = 1'b1;
    tick();
    check("idle_after_reset", obs(), ex(0, 0, 0, 0));

`ifdef SCAN_SEQUENCER_BLANK_EN
    // Mask 03, dwell 2: each position held two cycles, one blank cycle between.
    MASK  = 8'h03;
    DWELL = 16'd2;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      check("blank_seq", obs(), ex(1, tb_valid[k], tb_done[k], tb_sel[k]));
      if (k < 5) tick();
    end
    do_stop();
    check("blank_stop", obs(), ex(0, 0, 0, 0));

    // Single-bit mask still blanks between repeats; dwell 0 gives one cycle.
    MASK  = 8'h40;
    DWELL = 16'd0;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      check("blank_single", obs(), ex(1, (k % 2) == 0, (k % 2) == 0, 3'd6));
      tick();
    end
    do_stop();
    check("blank_single_stop", obs(), ex(0, 0, 0, 0));
`else
    // Full mask, dwell 3: 0..7 each for three cycles, done in the 24th.
    MASK  = 8'hFF;
    DWELL = 16'd3;
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      check("full_sweep", obs(), ex(1, 1, k == 23, 3'(k / 3)));
      tick();
    end
    check("full_wrap", obs(), ex(1, 1, 0, 0));
    do_stop();
    check("full_stop", obs(), ex(0, 0, 0, 0));

    // Sparse mask with zero dwell: 0,2,7 repeating one cycle each.
    MASK  = 8'b1000_0101;
    DWELL = 16'd0;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      check("sparse", obs(), ex(1, 1, t2_sel[k % 3] == 3'd7, t2_sel[k % 3]));
      tick();
    end
    do_stop();
    check("sparse_stop", obs(), ex(0, 0, 0, 0));

    // Mask and dwell changed while SEL=1 only apply from the next sweep.
    MASK  = 8'h0F;
    DWELL = 16'd0;
    pulse_start();
    for (int k = 0; k < 13; k++) begin
      check("mid_change", obs(), ex(1, 1, t3_done[k], t3_sel[k]));
      if (k == 1) begin
        MASK  = 8'hF0;
        DWELL = 16'd2;
      end
      tick();
    end
    do_stop();

    // Single bit: SEL constant, done every dwell; zero mask at wrap ends the scan.
    MASK  = 8'h10;
    DWELL = 16'd2;
    pulse_start();
    check("single_0", obs(), ex(1, 1, 0, 3'd4));
    tick();
    check("single_1", obs(), ex(1, 1, 1, 3'd4));
    tick();
    check("single_2", obs(), ex(1, 1, 0, 3'd4));
    MASK = 8'h00;
    tick();
    check("single_last", obs(), ex(1, 1, 1, 3'd4));
    tick();
    check("zero_mask_idle", obs(), ex(0, 0, 0, 0));

    // STOP with START at SEL=5 goes straight to IDLE with no done pulse.
    MASK  = 8'hFF;
    DWELL = 16'd0;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      check("pre_stop", obs(), ex(1, 1, 0, 3'(k)));
      if (k < 5) tick();
    end
    STOP  = 1'b1;
    START = 1'b1;
    tick();
    STOP  = 1'b0;
    START = 1'b0;
    check("stop_start", obs(), ex(0, 0, 0, 0));
`endif

    // START with an empty mask is ignored.
    MASK  = 8'h00;
    DWELL = 16'd4;
    pulse_start();
    check("start_zero_mask", obs(), ex(0, 0, 0, 0));
    tick();
    check("start_zero_mask_2", obs(), ex(0, 0, 0, 0));

    // Asynchronous reset mid-dwell clears outputs before the next edge.
    MASK  = 8'hFF;
    DWELL = 16'd5;
    pulse_start();
    tick();
    check("pre_reset", obs(), ex(1, 1, 0, 0));
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset", obs(), ex(0, 0, 0, 0));
    tick();
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_reset_idle", obs(), ex(0, 0, 0, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
